// File: rtl/mips_encode.sv
// mips_encode: packs symbolic MIPS instructions into 32-bit words and streams them into instruction memory
// Ports: clock/reset (sync, active-high); in_valid/in_ready handshake with op_sel, rs, rt, rd, imm, target;
// flush restarts at BASE_ADDR; wr_en/wr_addr/wr_data write port; err flags an illegal op_sel; count/full occupancy.
`ifndef OP_RTYPE
`define OP_RTYPE 6'h00
`define OP_J     6'h02
`define OP_BEQ   6'h04
`define OP_BNE   6'h05
`define OP_ADDI  6'h08
`define OP_ANDI  6'h0C
`define OP_ORI   6'h0D
`define OP_XORI  6'h0E
`define OP_LUI   6'h0F
`define OP_LW    6'h23
`define OP_LBU   6'h24
`define OP_SB    6'h28
`define OP_SW    6'h2B
`define OP0_JR   6'h08
`define OP0_ADD  6'h20
`define OP0_SUB  6'h22
`define OP0_AND  6'h24
`define OP0_OR   6'h25
`define OP0_XOR  6'h26
`define OP0_NOR  6'h27
`define OP0_SLT  6'h2A
`define OP0_ADDM 6'h2C
`endif
module mips_encode #(
  parameter int          DEPTH     = 64,
  parameter logic [31:0] BASE_ADDR = 32'h00400000
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [4:0]                   op_sel,
  input  logic [4:0]                   rs,
  input  logic [4:0]                   rt,
  input  logic [4:0]                   rd,
  input  logic [15:0]                  imm,
  input  logic [25:0]                  target,
  input  logic                         flush,
  output logic                         wr_en,
  output logic [31:0]                  wr_addr,
  output logic [31:0]                  wr_data,
  output logic                         err,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         full
);
  localparam int CW = $clog2(DEPTH+1);
  typedef enum logic {S_LOAD, S_FULL} state_t;
  state_t          r_state;
  logic [CW-1:0]   r_count;
  logic            r_wr_en;
  logic            r_err;
  logic [31:0]     r_wr_addr;
  logic [31:0]     r_wr_data;
  logic [31:0]     w_word;
  logic            w_legal;
  logic            w_xfer;
  always_comb begin
    w_legal = 1'b1;
    w_word  = '0;
    case (op_sel)
      5'd0:    w_word = {`OP_RTYPE, rs, rt, rd, 5'b0, `OP0_ADD};
      5'd1:    w_word = {`OP_RTYPE, rs, rt, rd, 5'b0, `OP0_SUB};
      5'd2:    w_word = {`OP_RTYPE, rs, rt, rd, 5'b0, `OP0_AND};
      5'd3:    w_word = {`OP_RTYPE, rs, rt, rd, 5'b0, `OP0_OR};
      5'd4:    w_word = {`OP_RTYPE, rs, rt, rd, 5'b0, `OP0_NOR};
      5'd5:    w_word = {`OP_RTYPE, rs, rt, rd, 5'b0, `OP0_XOR};
      5'd6:    w_word = {`OP_RTYPE, rs, rt, rd, 5'b0, `OP0_SLT};
      5'd7:    w_word = {`OP_RTYPE, rs, 15'b0, `OP0_JR};
      5'd8:    w_word = {`OP_RTYPE, rs, rt, rd, 5'b0, `OP0_ADDM};
      5'd9:    w_word = {`OP_ADDI, rs, rt, imm};
      5'd10:   w_word = {`OP_ANDI, rs, rt, imm};
      5'd11:   w_word = {`OP_ORI, rs, rt, imm};
      5'd12:   w_word = {`OP_XORI, rs, rt, imm};
      5'd13:   w_word = {`OP_LUI, 5'b0, rt, imm};
      5'd14:   w_word = {`OP_LW, rs, rt, imm};
      5'd15:   w_word = {`OP_LBU, rs, rt, imm};
      5'd16:   w_word = {`OP_SW, rs, rt, imm};
      5'd17:   w_word = {`OP_SB, rs, rt, imm};
      5'd18:   w_word = {`OP_BEQ, rs, rt, imm};
      5'd19:   w_word = {`OP_BNE, rs, rt, imm};
      5'd20:   w_word = {`OP_J, target};
      default: w_legal = 1'b0;
    endcase
  end
  assign full     = (r_state == S_FULL);
  assign in_ready = ~full & ~flush;
  assign w_xfer   = in_valid & in_ready;
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state   <= S_LOAD;
      r_count   <= '0;
      r_wr_en   <= 1'b0;
      r_err     <= 1'b0;
      r_wr_addr <= '0;
      r_wr_data <= '0;
    end else begin
      r_wr_en <= w_xfer & w_legal;
      r_err   <= w_xfer & ~w_legal;
      if (w_xfer & w_legal) begin
        r_wr_addr <= BASE_ADDR + (32'(r_count) << 2);
        r_wr_data <= w_word;
        r_count   <= r_count + 1'b1;
        if (r_count == CW'(DEPTH - 1)) r_state <= S_FULL;
      end
      // flush never coincides with a transfer since in_ready is low
      if (flush) begin
        r_count <= '0;
        r_state <= S_LOAD;
      end
    end
  end
  assign wr_en   = r_wr_en;
  assign err     = r_err;
  assign wr_addr = r_wr_addr;
  assign wr_data = r_wr_data;
  assign count   = r_count;
endmodule

// File: tb/tb_mips_encode.sv
// tb_mips_encode: randomized and directed checks of mips_encode against a table-driven reference model
module tb_mips_encode;
  localparam int DEPTH = 4;
  localparam logic [31:0] BASE = 32'h00400000;
  localparam logic [5:0] OPC [0:20] = '{6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00,
                                        6'h08, 6'h0C, 6'h0D, 6'h0E, 6'h0F, 6'h23, 6'h24, 6'h2B, 6'h28,
                                        6'h04, 6'h05, 6'h02};
  localparam logic [5:0] FN [0:8] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h27, 6'h26, 6'h2A, 6'h08, 6'h2C};
  logic clock = 1'b0;
  logic reset = 1'b1;
  logic in_valid = 1'b0;
  logic in_ready;
  logic [4:0] op_sel = '0, rs = '0, rt = '0, rd = '0;
  logic [15:0] imm = '0;
  logic [25:0] target = '0;
  logic flush = 1'b0;
  logic wr_en, err, full;
  logic [31:0] wr_addr, wr_data;
  logic [2:0] count;
  int checks = 0;
  int errors = 0;
  int n_err = 0;
  logic [63:0] wq [$];
  int m_count = 0;
  logic m_wr_en = 1'b0, m_err = 1'b0;
  logic [31:0] m_addr = '0, m_data = '0;
  mips_encode #(.DEPTH(DEPTH), .BASE_ADDR(BASE)) dut (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .op_sel(op_sel), .rs(rs), .rt(rt), .rd(rd), .imm(imm), .target(target),
    .flush(flush), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .err(err), .count(count), .full(full)
  );
  always #5 clock = ~clock;
  function automatic logic [31:0] enc(input int op, input logic [31:0] s, t, d, i, g);
    if (op <= 6 || op == 8) return (s << 21) | (t << 16) | (d << 11) | 32'(FN[op]);
    if (op == 7) return (s << 21) | 32'(FN[7]);
    if (op == 13) return (32'(OPC[13]) << 26) | (t << 16) | i;
    if (op == 20) return (32'(OPC[20]) << 26) | g;
    return (32'(OPC[op]) << 26) | (s << 21) | (t << 16) | i;
  endfunction
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%h exp=%h at %0t", name, act, exp, $time);
    end
  endtask
  always @(posedge clock) begin
    if (reset) begin
      m_count = 0; m_wr_en = 0; m_err = 0; m_addr = '0; m_data = '0;
    end else begin
      m_wr_en = 0;
      m_err = 0;
      if (in_valid && m_count != DEPTH && !flush) begin
        if (op_sel <= 20) begin
          m_wr_en = 1;
          m_addr = BASE + 4 * m_count;
          m_data = enc(int'(op_sel), 32'(rs), 32'(rt), 32'(rd), 32'(imm), 32'(target));
          m_count++;
        end else m_err = 1;
      end
      if (flush) m_count = 0;
    end
  end
  always @(negedge clock) begin
    chk("wr_en", 64'(wr_en), 64'(m_wr_en));
    chk("err", 64'(err), 64'(m_err));
    chk("count", 64'(count), 64'(m_count));
    chk("full", 64'(full), 64'(m_count == DEPTH));
    chk("in_ready", 64'(in_ready), 64'(m_count != DEPTH && !flush));
    if (m_wr_en) begin
      chk("wr_addr", 64'(wr_addr), 64'(m_addr));
      chk("wr_data", 64'(wr_data), 64'(m_data));
    end
    if (wr_en) wq.push_back({wr_addr, wr_data});
    if (err) n_err++;
  end
  task automatic tick();
    @(posedge clock);
    #2;
  endtask
  task automatic send(input logic [4:0] op, input logic [4:0] a, b, c, input logic [15:0] im, input logic [25:0] tg);
    in_valid = 1; op_sel = op; rs = a; rt = b; rd = c; imm = im; target = tg;
    tick();
    in_valid = 0;
  endtask
  task automatic do_reset();
    reset = 1;
    tick();
    reset = 0;
    tick();
    wq.delete();
    n_err = 0;
  endtask
  initial begin
    tick();
    do_reset();
    send(0, 1, 2, 3, 0, 0);
    tick();
    chk("add_n", 64'(wq.size()), 64'd1);
    chk("add_w", wq[0], {32'h00400000, 32'h00221820});
    chk("add_cnt", 64'(count), 64'd1);
    do_reset();
    send(9, 1, 2, 0, 16'd5, 0);
    send(14, 5, 4, 0, 16'd8, 0);
    send(20, 0, 0, 0, 0, 26'h0100000);
    send(7, 31, 7, 7, 0, 0);
    tick();
    chk("b2b_n", 64'(wq.size()), 64'd4);
    chk("b2b_w0", wq[0], {32'h00400000, 32'h20220005});
    chk("b2b_w1", wq[1], {32'h00400004, 32'h8CA40008});
    chk("b2b_w2", wq[2], {32'h00400008, 32'h08100000});
    chk("b2b_w3", wq[3], {32'h0040000C, 32'h03E00008});
    chk("b2b_cnt", 64'(count), 64'd4);
    do_reset();
    send(0, 1, 2, 3, 0, 0);
    send(25, 1, 2, 3, 0, 0);
    send(0, 4, 5, 6, 0, 0);
    tick();
    chk("ill_err", 64'(n_err), 64'd1);
    chk("ill_n", 64'(wq.size()), 64'd2);
    chk("ill_addr", 64'(wq[1][63:32]), 64'h00400004);
    chk("ill_cnt", 64'(count), 64'd2);
    do_reset();
    in_valid = 1; op_sel = 0; rs = 3; rt = 4; rd = 5;
    repeat (5) tick();
    in_valid = 0;
    tick();
    chk("full_n", 64'(wq.size()), 64'd4);
    chk("full_f", 64'(full), 64'd1);
    chk("full_rdy", 64'(in_ready), 64'd0);
    do_reset();
    repeat (3) send(0, 1, 1, 1, 0, 0);
    in_valid = 1; flush = 1; op_sel = 0; rs = 9; rt = 9; rd = 9;
    tick();
    in_valid = 0; flush = 0;
    chk("flush_cnt", 64'(count), 64'd0);
    send(0, 1, 2, 3, 0, 0);
    tick();
    chk("flush_n", 64'(wq.size()), 64'd4);
    chk("flush_addr", 64'(wq[3][63:32]), 64'h00400000);
    in_valid = 1; reset = 1; op_sel = 0;
    tick();
    in_valid = 0; reset = 0;
    chk("rst_we", 64'(wr_en), 64'd0);
    chk("rst_cnt", 64'(count), 64'd0);
    chk("rst_out", {wr_addr, wr_data}, 64'd0);
    chk("rst_err", 64'(err), 64'd0);
    chk("rst_full", 64'(full), 64'd0);
    chk("rst_rdy", 64'(in_ready), 64'd1);
    for (int i = 0; i < 3000; i++) begin
      reset = ($urandom_range(99) == 0);
      flush = ($urandom_range(19) == 0);
      in_valid = ($urandom_range(9) < 7);
      op_sel = ($urandom_range(3) == 0) ? 5'($urandom_range(31, 21)) : 5'($urandom_range(20));
      rs = 5'($urandom); rt = 5'($urandom); rd = 5'($urandom);
      imm = 16'($urandom); target = 26'($urandom);
      tick();
    end
    reset = 0; flush = 0; in_valid = 0;
    repeat (2) tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/mips_encode.md
# mips_encode

Streaming MIPS instruction encoder: the inverse of `mips_decode`. It accepts one symbolic instruction per handshake (mnemonic select plus register/immediate/target fields), packs it into a 32-bit MIPS word, and writes it sequentially into instruction memory. It sits between the bench or boot loader and the instruction memory of the single-cycle datapath, so programs can be built from fields without a hand-assembled hex image.

## Interface
- `DEPTH`, 64: number of instruction words the block may write before reporting full.
- `BASE_ADDR`, 32'h00400000: byte address of the first instruction written.
- `clock`  in  1  system clock; all state changes on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  instruction fields are valid this cycle.
- `in_ready`  out  1  block can accept an instruction this cycle.
- `op_sel`  in  5  mnemonic select: 0 add, 1 sub, 2 and, 3 or, 4 nor, 5 xor, 6 slt, 7 jr, 8 addm, 9 addi, 10 andi, 11 ori, 12 xori, 13 lui, 14 lw, 15 lbu, 16 sw, 17 sb, 18 beq, 19 bne, 20 j; 21–31 are illegal.
- `rs`, `rt`, `rd`  in  5 each  register fields.
- `imm`  in  16  immediate or branch offset, passed through unmodified.
- `target`  in  26  jump target field.
- `flush`  in  1  restart loading at `BASE_ADDR`.
- `wr_en`  out  1  instruction-memory write strobe.
- `wr_addr`  out  32  byte address of the write.
- `wr_data`  out  32  encoded instruction.
- `err`  out  1  one-cycle pulse when an illegal `op_sel` is consumed.
- `count`  out  ceil(log2(DEPTH+1))  number of words written since reset or flush.
- `full`  out  1  `count == DEPTH`.

## Operation
- Opcodes and funct codes come from the shared `OP_*` and `OP0_*` defines that `mips_decode` also uses, so the two blocks always agree.
- R-type (add, sub, and, or, nor, xor, slt, addm):
  - Fields: {6'b0, rs, rt, rd, 5'b0, funct}.
- jr:
  - Fields: {6'b0, rs, 15'b0, `OP0_JR`}.
  - `rt` and `rd` are ignored.
- I-type (addi, andi, ori, xori, lw, lbu, sw, sb, beq, bne):
  - Fields: {opcode, rs, rt, imm}.
- lui:
  - Fields: {`OP_LUI`, 5'b0, rt, imm}.
  - `rs` is ignored.
- j:
  - Fields: {`OP_J`, target}.
- Handshake: a transfer happens on a rising edge where `in_valid & in_ready`.
- `in_ready = ~full & ~flush`. It is not gated by reset, because reset is synchronous.
- FSM has two states:
  - LOAD: reset state.
  - FULL: entered when an accepted legal instruction brings `count` to `DEPTH`.
  - FULL → LOAD only on `flush` or `reset`.
- Accepted legal instruction:
  - The write registers are loaded with `wr_addr = BASE_ADDR + 4*count` (pre-increment value) and the encoded word.
  - `count` increments.
- Accepted illegal instruction:
  - No write occurs.
  - `err` pulses.
  - `count` is unchanged.
  - The state does not change.
- `flush` takes priority over a simultaneous transfer:
  - The transfer is not accepted, because `in_ready` is low.
  - `count` is cleared to 0 and the FSM returns to LOAD.
  - A write already registered from the previous cycle still completes.
- `count` never wraps. In FULL, `in_valid` is ignored and the source must hold its fields.
- Unused input fields never affect `wr_data`.

## Timing
- Latency is one cycle. A transfer at edge N gives `wr_en = 1` with valid `wr_addr`/`wr_data` during cycle N+1. Likewise, `err` is high during cycle N+1.
- `wr_en` and `err` are single-cycle pulses; they are high only in the cycle after a transfer.
- Back-to-back transfers are supported every cycle, giving sustained throughput of 1 word per cycle.
- `count` and `full` update at the same edge as the transfer, so `in_ready` drops in the cycle immediately after the last slot is filled.
- Reset values, including on reset mid-operation:
  - `wr_en`, `err` = 0; `wr_addr`, `wr_data`, `count` = 0.
  - `full` = 0; `in_ready` = 1 (when `flush` = 0); FSM in LOAD.
  - A pending registered write is dropped.

## Test plan
- add: transfer `op_sel`=0, rs=1, rt=2, rd=3 after reset -> next cycle `wr_en`=1, `wr_addr`=0x00400000, `wr_data`=0x00221820, `count`=1.
- Back-to-back stream over 4 cycles:
  - Stimulus: addi rs=1 rt=2 imm=5; lw rs=5 rt=4 imm=8; j target=0x0100000; jr rs=31 (rt and rd driven to 7).
  - Response: consecutive writes 0x20220005 @0x00400000, 0x8CA40008 @0x00400004, 0x08100000 @0x00400008, 0x03E00008 @0x0040000C; `count`=4.
- Illegal `op_sel`=25 between two legal adds:
  - `err` pulses once and `wr_en` stays 0 in that cycle.
  - The second add writes at 0x00400004.
  - `count`=2.
- Full boundary (DEPTH=4):
  - Stimulus: 5 transfers attempted with `in_valid` held high.
  - Response: exactly 4 writes; `full`=1 and `in_ready`=0 from the cycle after the 4th; the 5th is never accepted.
- `flush` asserted with `in_valid` while `count`=3:
  - No transfer is accepted.
  - `count`=0.
  - The next add writes at 0x00400000.
- Reset asserted in the cycle a transfer occurs -> `wr_en`=0 next cycle, `count`=0, all outputs at reset values.
